// File: rtl/enc_pkg.sv
// rtl/enc_pkg.sv - shared state encodings, width defaults and clog2 for the serial 8x3 encoder
package enc_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    // Ceiling log2; returns 0 for values of 0 and 1.
    function automatic int clog2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    localparam int N_IN_DEF  = 8;
    localparam int OUT_W_DEF = clog2(N_IN_DEF);

endpackage

// File: rtl/priority_encoder_8x3.sv
// rtl/priority_encoder_8x3.sv - combinational priority encoder, search direction set by ENC_MSB_FIRST_EN
module priority_encoder_8x3
    import enc_pkg::*;
#(
    parameter int N_IN  = N_IN_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic [N_IN-1:0]  i_pending,
    output logic [OUT_W-1:0] o_index,
    output logic [N_IN-1:0]  o_mask
);

    // Select one set bit; the last match in loop order wins, so the loop
    // runs towards the bit that must take priority. Zero input gives 0/0.
    always_comb begin
        o_index = '0;
        o_mask  = '0;
`ifdef ENC_MSB_FIRST_EN
        for (int i = 0; i < N_IN; i++) begin
            if (i_pending[i]) begin
                o_index   = OUT_W'(i);
                o_mask    = '0;
                o_mask[i] = 1'b1;
            end
        end
`else
        for (int i = N_IN - 1; i >= 0; i--) begin
            if (i_pending[i]) begin
                o_index   = OUT_W'(i);
                o_mask    = '0;
                o_mask[i] = 1'b1;
            end
        end
`endif
    end

endmodule

// File: rtl/encoder_8x3_serial.sv
// rtl/encoder_8x3_serial.sv - serialises set bits of a request vector into indices; ENC_MSB_FIRST_EN selects descending order
module encoder_8x3_serial
    import enc_pkg::*;
#(
    parameter int N_IN  = N_IN_DEF,
    parameter int OUT_W = clog2(N_IN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IN-1:0]  data_in,
    input  logic             load,
    output logic             in_ready,
    output logic [OUT_W-1:0] data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             done
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [N_IN-1:0]  r_pending;
    logic [N_IN-1:0]  w_pending_nxt;
    logic [N_IN-1:0]  r_mask;
    logic [OUT_W-1:0] r_data_out;
    logic             r_out_valid;
    logic             w_out_valid_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             r_in_ready;
    logic [OUT_W-1:0] w_idx_nxt;
    logic [N_IN-1:0]  w_mask_nxt;

    // The encoder looks at the pending vector as it will be after this edge,
    // so index and clear mask are registered alongside it and every output
    // comes straight from a flop.
    priority_encoder_8x3 #(
        .N_IN  (N_IN),
        .OUT_W (OUT_W)
    ) u_prio (
        .i_pending (w_pending_nxt),
        .o_index   (w_idx_nxt),
        .o_mask    (w_mask_nxt)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, next pending vector, next valid and drain pulse.
    always_comb begin
        w_state_nxt     = r_state;
        w_pending_nxt   = r_pending;
        w_out_valid_nxt = r_out_valid;
        w_done_nxt      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (load && r_in_ready) begin
                    if (data_in != '0) begin
                        w_pending_nxt   = data_in;
                        w_out_valid_nxt = 1'b1;
                        w_state_nxt     = ST_EMIT;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end
            ST_EMIT: begin
                if (r_out_valid && out_ready) begin
                    w_pending_nxt = r_pending & ~r_mask;
                    if ((r_pending & ~r_mask) == '0) begin
                        w_out_valid_nxt = 1'b0;
                        w_done_nxt      = 1'b1;
                        w_state_nxt     = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_pending_nxt   = '0;
                w_out_valid_nxt = 1'b0;
            end
        endcase
    end

    // Datapath and output registers; in_ready mirrors the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending   <= '0;
            r_mask      <= '0;
            r_data_out  <= '0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_pending   <= w_pending_nxt;
            r_mask      <= w_mask_nxt;
            r_data_out  <= w_idx_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_done      <= w_done_nxt;
            r_in_ready  <= (w_state_nxt == ST_IDLE);
        end
    end

    assign in_ready  = r_in_ready;
    assign data_out  = r_data_out;
    assign out_valid = r_out_valid;
    assign done      = r_done;

endmodule

// File: tb/tb_encoder_8x3_serial.sv
// tb/tb_encoder_8x3_serial.sv - directed self-checking bench for encoder_8x3_serial
module tb_encoder_8x3_serial;

    logic       clk;
    logic       rst;
    logic [7:0] data_in;
    logic       load;
    logic       in_ready;
    logic [2:0] data_out;
    logic       out_valid;
    logic       out_ready;
    logic       done;

    int checks;
    int errors;

    logic [2:0] exp_a5 [4];
    logic [2:0] exp_18 [2];
    logic [2:0] exp_06 [2];
    logic [7:0] decoded;

    encoder_8x3_serial dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .load      (load),
        .in_ready  (in_ready),
        .data_out  (data_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("%s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
`ifdef ENC_MSB_FIRST_EN
        exp_a5[0] = 3'd7; exp_a5[1] = 3'd5; exp_a5[2] = 3'd2; exp_a5[3] = 3'd0;
        exp_18[0] = 3'd4; exp_18[1] = 3'd3;
        exp_06[0] = 3'd2; exp_06[1] = 3'd1;
`else
        exp_a5[0] = 3'd0; exp_a5[1] = 3'd2; exp_a5[2] = 3'd5; exp_a5[3] = 3'd7;
        exp_18[0] = 3'd3; exp_18[1] = 3'd4;
        exp_06[0] = 3'd1; exp_06[1] = 3'd2;
`endif
        rst       = 1'b1;
        load      = 1'b0;
        data_in   = 8'h00;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst0_valid", 32'(out_valid), 32'd0);
        chk("rst0_ready", 32'(in_ready), 32'd1);
        chk("rst0_done", 32'(done), 32'd0);
        chk("rst0_data", 32'(data_out), 32'd0);

        // 1: reset in the middle of an 8'hFF drain
        data_in   = 8'hFF;
        load      = 1'b1;
        out_ready = 1'b1;
        tick();
        load = 1'b0;
        chk("ff_first_valid", 32'(out_valid), 32'd1);
        tick();
        chk("ff_second_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst1_valid", 32'(out_valid), 32'd0);
        chk("rst1_ready", 32'(in_ready), 32'd1);
        chk("rst1_done", 32'(done), 32'd0);
        chk("rst1_data", 32'(data_out), 32'd0);
        tick();
        chk("rst1_no_resume", 32'(out_valid), 32'd0);

        // 2: one-hot sweep with loopback decode
        for (int v = 0; v < 8; v++) begin
            data_in = 8'h01 << v;
            load    = 1'b1;
            tick();
            load = 1'b0;
            decoded = 8'h01 << data_out;
            chk("hot_valid", 32'(out_valid), 32'd1);
            chk("hot_index", 32'(data_out), 32'(v));
            chk("hot_loopback", 32'(decoded), 32'(data_in));
            chk("hot_busy", 32'(in_ready), 32'd0);
            tick();
            chk("hot_done", 32'(done), 32'd1);
            chk("hot_drained", 32'(out_valid), 32'd0);
            chk("hot_ready", 32'(in_ready), 32'd1);
            tick();
            chk("hot_done_pulse", 32'(done), 32'd0);
        end

        // 3: multi-bit 8'hA5
        data_in = 8'hA5;
        load    = 1'b1;
        tick();
        load = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("a5_valid", 32'(out_valid), 32'd1);
            chk("a5_index", 32'(data_out), 32'(exp_a5[k]));
            chk("a5_no_done", 32'(done), 32'd0);
            tick();
        end
        chk("a5_done", 32'(done), 32'd1);
        chk("a5_drained", 32'(out_valid), 32'd0);
        tick();

        // 4: backpressure on 8'h18
        out_ready = 1'b0;
        data_in   = 8'h18;
        load      = 1'b1;
        tick();
        load = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_index", 32'(data_out), 32'(exp_18[0]));
            tick();
        end
        out_ready = 1'b1;
        chk("bp_release_index", 32'(data_out), 32'(exp_18[0]));
        tick();
        chk("bp_second_index", 32'(data_out), 32'(exp_18[1]));
        chk("bp_second_valid", 32'(out_valid), 32'd1);
        tick();
        chk("bp_done", 32'(done), 32'd1);
        chk("bp_drained", 32'(out_valid), 32'd0);
        tick();

        // 5a: zero vector
        data_in = 8'h00;
        load    = 1'b1;
        tick();
        load = 1'b0;
        chk("zero_valid", 32'(out_valid), 32'd0);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_ready", 32'(in_ready), 32'd1);
        tick();
        chk("zero_done_pulse", 32'(done), 32'd0);

        // 5b: load during EMIT ignored, load on final handshake deferred
        data_in = 8'h06;
        load    = 1'b1;
        tick();
        chk("ign_first", 32'(data_out), 32'(exp_06[0]));
        data_in = 8'h40;
        tick();
        chk("ign_second", 32'(data_out), 32'(exp_06[1]));
        chk("ign_second_valid", 32'(out_valid), 32'd1);
        tick();
        chk("ign_done", 32'(done), 32'd1);
        chk("ign_not_taken", 32'(out_valid), 32'd0);
        chk("ign_ready", 32'(in_ready), 32'd1);
        tick();
        load = 1'b0;
        chk("late_valid", 32'(out_valid), 32'd1);
        chk("late_index", 32'(data_out), 32'd6);
        chk("late_no_done", 32'(done), 32'd0);
        tick();
        chk("late_done", 32'(done), 32'd1);
        chk("late_drained", 32'(out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
